// File: rtl/mux_nto1_scan_if.sv
// Bus bundle for mux_nto1_scan: packed input channels, select/mode/enable
// controls, and the registered selection results.
interface mux_nto1_scan_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
);
  logic [N*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic               en;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic [SEL_W-1:0]   cur_sel;
  logic               wrap;
  logic               sel_err;

  modport master (
    output in_bus, sel, mode, en,
    input  out, out_valid, cur_sel, wrap, sel_err
  );

  modport slave (
    input  in_bus, sel, mode, en,
    output out, out_valid, cur_sel, wrap, sel_err
  );
endinterface

// File: rtl/mux_nto1_scan.sv
// N-to-1 registered mux with a manual-select mode and a dwell-timed
// round-robin scan mode; all outputs come straight from flops.
module mux_nto1_scan #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned DWELL = 2,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  mux_nto1_scan_if.slave bus
);

  localparam int unsigned    CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_base;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             sel_ok;
  logic [WIDTH-1:0] chan [N];

  // Unpack the flat input bus into addressable channels
  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      chan[k] = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  assign sel_ok = (32'(bus.sel) < N);

  // Next-state and next-output decisions
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    valid_d  = valid_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    err_d    = err_q;
    cnt_base = (state_q == SCAN) ? cnt_q : '0;

    if (bus.en) begin
      valid_d = 1'b1;
      state_d = bus.mode ? SCAN : MANUAL;
      cnt_d   = '0;
      err_d   = 1'b0;
      if (!bus.mode) begin
        if (sel_ok) begin
          out_d = chan[bus.sel];
          cur_d = bus.sel;
        end else begin
          out_d = '0;
          err_d = 1'b1;
        end
      end else begin
        out_d = chan[cur_q];
        // Dwell expired: step to the next channel, folding N-1 back to 0
        if (cnt_base == LAST_CNT) begin
          cur_d  = (cur_q == LAST_SEL) ? '0 : cur_q + SEL_W'(1);
          wrap_d = (cur_q == LAST_SEL);
        end else begin
          cnt_d = cnt_base + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MANUAL;
      out_q   <= '0;
      valid_q <= 1'b0;
      cur_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.cur_sel   = cur_q;
  assign bus.wrap      = wrap_q;
  assign bus.sel_err   = err_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Drives three configurations (N=4/DWELL=2, N=3/DWELL=2, N=4/DWELL=1) from
// one stimulus stream and compares every output against a behavioural model.
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_bus;
  logic [1:0]  sel;
  logic        mode;
  logic        en;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mux_nto1_scan_if #(.WIDTH(4), .N(4)) ifa ();
  mux_nto1_scan_if #(.WIDTH(4), .N(3)) ifb ();
  mux_nto1_scan_if #(.WIDTH(4), .N(4)) ifc ();

  assign ifa.in_bus = in_bus;
  assign ifb.in_bus = in_bus[11:0];
  assign ifc.in_bus = in_bus;
  assign ifa.sel = sel;   assign ifb.sel = sel;   assign ifc.sel = sel;
  assign ifa.mode = mode; assign ifb.mode = mode; assign ifc.mode = mode;
  assign ifa.en = en;     assign ifb.en = en;     assign ifc.en = en;

  mux_nto1_scan #(.WIDTH(4), .N(4), .DWELL(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux_nto1_scan #(.WIDTH(4), .N(3), .DWELL(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  mux_nto1_scan #(.WIDTH(4), .N(4), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // Reference model: one entry per configuration
  int nn [3] = '{4, 3, 4};
  int dd [3] = '{2, 2, 1};
  int m_out [3];
  int m_val [3];
  int m_cur [3];
  int m_cnt [3];
  int m_wrap [3];
  int m_err [3];
  int wraps_a;

  function automatic int chan_of(input logic [15:0] bus_v, input int k);
    return int'((bus_v >> (4 * k)) & 16'h000F);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_out[i] = 0; m_val[i] = 0; m_cur[i] = 0;
        m_cnt[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
      end else if (!en) begin
        m_wrap[i] = 0;
      end else begin
        m_val[i]  = 1;
        m_wrap[i] = 0;
        if (!mode) begin
          m_cnt[i] = 0;
          if (int'(sel) < nn[i]) begin
            m_out[i] = chan_of(in_bus, int'(sel));
            m_cur[i] = int'(sel);
            m_err[i] = 0;
          end else begin
            m_out[i] = 0;
            m_err[i] = 1;
          end
        end else begin
          m_err[i] = 0;
          m_out[i] = chan_of(in_bus, m_cur[i]);
          m_cnt[i] = m_cnt[i] + 1;
          if (m_cnt[i] == dd[i]) begin
            m_cnt[i]  = 0;
            m_wrap[i] = (m_cur[i] == nn[i] - 1) ? 1 : 0;
            m_cur[i]  = (m_cur[i] + 1) % nn[i];
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " a.out"},       32'(ifa.out),       32'(m_out[0]));
    check({tag, " a.out_valid"}, 32'(ifa.out_valid), 32'(m_val[0]));
    check({tag, " a.cur_sel"},   32'(ifa.cur_sel),   32'(m_cur[0]));
    check({tag, " a.wrap"},      32'(ifa.wrap),      32'(m_wrap[0]));
    check({tag, " a.sel_err"},   32'(ifa.sel_err),   32'(m_err[0]));
    check({tag, " b.out"},       32'(ifb.out),       32'(m_out[1]));
    check({tag, " b.out_valid"}, 32'(ifb.out_valid), 32'(m_val[1]));
    check({tag, " b.cur_sel"},   32'(ifb.cur_sel),   32'(m_cur[1]));
    check({tag, " b.wrap"},      32'(ifb.wrap),      32'(m_wrap[1]));
    check({tag, " b.sel_err"},   32'(ifb.sel_err),   32'(m_err[1]));
    check({tag, " c.out"},       32'(ifc.out),       32'(m_out[2]));
    check({tag, " c.out_valid"}, 32'(ifc.out_valid), 32'(m_val[2]));
    check({tag, " c.cur_sel"},   32'(ifc.cur_sel),   32'(m_cur[2]));
    check({tag, " c.wrap"},      32'(ifc.wrap),      32'(m_wrap[2]));
    check({tag, " c.sel_err"},   32'(ifc.sel_err),   32'(m_err[2]));
  endtask

  // Apply one cycle of stimulus, advance the model, then compare
  task automatic step(input string tag, input logic r, input logic e,
                      input logic m, input logic [1:0] s);
    rst = r; en = e; mode = m; sel = s;
    @(posedge clk);
    model_edge();
    #1;
    if (ifa.wrap === 1'b1) wraps_a++;
    check_all(tag);
  endtask

  initial begin
    in_bus  = 16'hFA50;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0;
    wraps_a = 0;

    step("reset", 1'b1, 1'b0, 1'b0, 2'd0);
    step("reset", 1'b1, 1'b1, 1'b1, 2'd2);

    for (int s = 0; s < 4; s++) begin
      step("manual", 1'b0, 1'b1, 1'b0, 2'(s));
      step("manual", 1'b0, 1'b1, 1'b0, 2'(s));
    end
    check("manual_last_out_const", 32'(ifa.out), 32'hF);

    step("to_ch0", 1'b0, 1'b1, 1'b0, 2'd0);
    wraps_a = 0;
    for (int c = 0; c < 9; c++) step("scan9", 1'b0, 1'b1, 1'b1, 2'd3);
    check("scan9_wrap_count", 32'(wraps_a), 32'd1);

    step("scan_pre_hold", 1'b0, 1'b1, 1'b1, 2'd0);
    for (int c = 0; c < 3; c++) step("hold", 1'b0, 1'b0, 1'b0, 2'd1);
    for (int c = 0; c < 4; c++) step("resume", 1'b0, 1'b1, 1'b1, 2'd1);

    step("bad_sel", 1'b0, 1'b1, 1'b0, 2'd3);
    check("bad_sel_b_err_const", 32'(ifb.sel_err), 32'd1);
    step("good_sel", 1'b0, 1'b1, 1'b0, 2'd1);
    check("good_sel_b_out_const", 32'(ifb.out), 32'h5);

    step("to_ch0", 1'b0, 1'b1, 1'b0, 2'd0);
    for (int c = 0; c < 4; c++) step("scan_to2", 1'b0, 1'b1, 1'b1, 2'd0);
    check("pre_rst_a_cur", 32'(ifa.cur_sel), 32'd2);
    step("mid_rst", 1'b1, 1'b1, 1'b1, 2'd0);
    check("mid_rst_a_cur_const", 32'(ifa.cur_sel), 32'd0);
    for (int c = 0; c < 6; c++) step("rescan", 1'b0, 1'b1, 1'b1, 2'd0);

    for (int c = 0; c < 400; c++) begin
      in_bus = 16'($urandom);
      step("random", ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
